// File: rtl/seq_pkg.sv
// Shared frame definitions for the sequence detector and its serializer feeder.
// Both blocks import FRAME_W from here so their frame alignment cannot drift apart.
package seq_pkg;

  localparam int FRAME_W = 4;
  localparam logic [FRAME_W-1:0] IDLE_WORD = {FRAME_W{1'b0}};

  typedef enum logic {
    IDLE_TX = 1'b0,
    DATA_TX = 1'b1
  } tx_state_e;

endpackage : seq_pkg

// File: rtl/seq_word_fifo.sv
// Small word FIFO feeding the serializer; pointers carry an extra wrap bit so
// full and empty are told apart without an occupancy counter.
module seq_word_fifo
  import seq_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = FRAME_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + (AW+1)'(1);
    if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which
  // entries are valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule : seq_word_fifo

// File: rtl/seq_frame_serializer.sv
// Serializes queued 4-bit words MSB-first into a never-stalling bit stream whose
// frame boundaries stay locked to reset release; idle frames fill the gaps.
module seq_frame_serializer #(
  parameter int                            FRAME_W   = seq_pkg::FRAME_W,
  parameter int                            DEPTH     = 2,
  parameter logic [seq_pkg::FRAME_W-1:0]   IDLE_WORD = seq_pkg::IDLE_WORD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic               out,
  output logic               frame_start,
  output logic               frame_is_data,
  output logic [7:0]         frames_sent
);

  import seq_pkg::*;

  localparam int                BCNT_W    = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(FRAME_W - 1);

  logic               fifo_full;
  logic               fifo_empty;
  logic [FRAME_W-1:0] fifo_rdata;
  logic               push;
  logic               pop;
  logic               boundary;

  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [7:0]         frames_sent_q, frames_sent_d;
  tx_state_e          state_q, state_d;

  // A word pushed on a boundary edge is not yet visible to the pop decision,
  // because pop looks only at the registered empty flag.
  assign boundary = (bcnt_q == BCNT_LAST);
  assign push     = din_valid && !fifo_full;
  assign pop      = boundary && !fifo_empty;

  seq_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FRAME_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (din),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE_TX;
    else        state_q <= state_d;
  end

  // NOTE: each combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (boundary) state_d = fifo_empty ? IDLE_TX : DATA_TX;
  end

  always_comb begin
    frame_is_data = (state_q == DATA_TX);
    din_ready     = !fifo_full;
    out           = sh_q[FRAME_W-1];
    frame_start   = (bcnt_q == '0);
    frames_sent   = frames_sent_q;
  end

  always_comb begin
    sh_d          = sh_q << 1;
    bcnt_d        = bcnt_q + BCNT_W'(1);
    frames_sent_d = frames_sent_q;
    if (boundary) begin
      bcnt_d = '0;
      sh_d   = pop ? fifo_rdata : IDLE_WORD;
      if (pop) frames_sent_d = frames_sent_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q          <= IDLE_WORD;
      bcnt_q        <= '0;
      frames_sent_q <= '0;
    end else begin
      sh_q          <= sh_d;
      bcnt_q        <= bcnt_d;
      frames_sent_q <= frames_sent_d;
    end
  end

endmodule : seq_frame_serializer

// File: tb/tb_seq_frame_serializer.sv
// Self-checking bench for seq_frame_serializer: a frame-level reference model
// with a word scoreboard is compared against every output on every cycle.
module tb_seq_frame_serializer;

  localparam int FW    = 4;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic          out;
  logic          frame_start;
  logic          frame_is_data;
  logic [7:0]    frames_sent;

  seq_frame_serializer #(
    .FRAME_W   (FW),
    .DEPTH     (DEPTH),
    .IDLE_WORD (4'b0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .din           (din),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .out           (out),
    .frame_start   (frame_start),
    .frame_is_data (frame_is_data),
    .frames_sent   (frames_sent)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: scoreboard of accepted words plus the current frame.
  logic [FW-1:0] m_q [$];
  int            m_bcnt;
  logic [FW-1:0] m_sh;
  logic          m_data;
  logic [7:0]    m_sent;
  logic          last_accept;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_bcnt = 0;
    m_sh   = 4'b0000;
    m_data = 1'b0;
    m_sent = 8'd0;
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance both.
  task automatic tick(input logic v, input logic [FW-1:0] d);
    din_valid = v;
    din       = d;
    check("out",           32'(out),           32'(m_sh[FW-1]));
    check("frame_start",   32'(frame_start),   32'(m_bcnt == 0));
    check("frame_is_data", 32'(frame_is_data), 32'(m_data));
    check("din_ready",     32'(din_ready),     32'(m_q.size() < DEPTH));
    check("frames_sent",   32'(frames_sent),   32'(m_sent));
    last_accept = v && (m_q.size() < DEPTH);
    if (m_bcnt == FW-1) begin
      m_bcnt = 0;
      if (m_q.size() != 0) begin
        m_sh   = m_q.pop_front();
        m_data = 1'b1;
        m_sent = m_sent + 8'd1;
      end else begin
        m_sh   = 4'b0000;
        m_data = 1'b0;
      end
    end else begin
      m_sh   = m_sh << 1;
      m_bcnt = m_bcnt + 1;
    end
    if (last_accept) m_q.push_back(d);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out"},   32'(out),           32'd0);
    check({tag, "_fs"},    32'(frame_start),   32'd1);
    check({tag, "_data"},  32'(frame_is_data), 32'd0);
    check({tag, "_ready"}, 32'(din_ready),     32'd1);
    check({tag, "_sent"},  32'(frames_sent),   32'd0);
  endtask

  // Leaves the bench in cycle 0: just after release, before the first edge.
  task automatic do_reset();
    rst_n     = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    @(posedge clk);
    #1;
    model_reset();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [FW-1:0] bits;
    int acc;
    int w;
    int df;
    int gaps;

    // Reset only: idle frames, boundaries at 0, 4, 8.
    do_reset();
    repeat (12) tick(1'b0, '0);
    check("t1_sent", 32'(frames_sent), 32'd0);

    // Single word pushed at cycle 1 goes out at cycles 4-7.
    do_reset();
    tick(1'b0, '0);
    tick(1'b1, 4'b1011);
    bits = '0;
    while (cyc < 8) begin
      if (cyc >= 4) bits = {bits[FW-2:0], out};
      tick(1'b0, '0);
    end
    check("t2_word",  32'(bits),          32'hB);
    check("t2_sent",  32'(frames_sent),   32'd1);
    check("t2_idle",  32'(frame_is_data), 32'd0);
    check("t2_start", 32'(frame_start),   32'd1);

    // Fill the FIFO, hold a third word until ready returns after the pop.
    do_reset();
    tick(1'b1, 4'b1000);
    tick(1'b1, 4'b0111);
    check("t3_ready_c2", 32'(din_ready), 32'd0);
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      int c;
      c = cyc;
      tick(1'b1, 4'b0101);
      if (last_accept) acc = c;
    end
    check("t3_acc_cyc", 32'(acc), 32'd4);
    bits = '0;
    while (cyc < 16) begin
      if (cyc >= 8 && cyc < 12) bits = {bits[FW-2:0], out};
      tick(1'b0, '0);
    end
    check("t3_second", 32'(bits), 32'h7);

    // Push on the boundary edge with an empty FIFO: word waits a full frame.
    do_reset();
    repeat (3) tick(1'b0, '0);
    tick(1'b1, 4'b1101);
    check("t4_c4_idle", 32'(frame_is_data), 32'd0);
    bits = '0;
    while (cyc < 12) begin
      if (cyc == 8) check("t4_c8_data", 32'(frame_is_data), 32'd1);
      if (cyc >= 8) bits = {bits[FW-2:0], out};
      tick(1'b0, '0);
    end
    check("t4_word", 32'(bits), 32'hD);

    // Continuous stream of 300 words: no idle gaps, counter wraps to 44.
    do_reset();
    w = 0;
    df = 0;
    gaps = 0;
    for (int i = 0; i < 1400; i++) begin
      if (frame_start) begin
        if (frame_is_data) df++;
        else if (df > 0)   gaps++;
      end
      if (df == 300) break;
      tick(w < 300, 4'(w * 5 + 3));
      if (last_accept) w++;
    end
    check("t5_frames", 32'(df),          32'd300);
    check("t5_gaps",   32'(gaps),        32'd0);
    check("t5_sent",   32'(frames_sent), 32'd44);

    // Reset mid-frame with two words queued: everything returns at once.
    do_reset();
    tick(1'b1, 4'b1110);
    tick(1'b1, 4'b1001);
    tick(1'b0, '0);
    tick(1'b0, '0);
    tick(1'b1, 4'b0110);
    tick(1'b0, '0);
    check("t6_pre_data",  32'(frame_is_data), 32'd1);
    check("t6_pre_ready", 32'(din_ready),     32'd0);
    check("t6_pre_sent",  32'(frames_sent),   32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    cyc   = 0;
    repeat (12) tick(1'b0, '0);
    check("t6_sent", 32'(frames_sent), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_seq_frame_serializer
